uart_fifo_bridge: RTL
=====================

Name: uart_fifo_bridge

Overview:
- Core-side byte buffering between the core's UART register interface and the uart byte engine (tx_valid/tx_busy/rx_valid).
- TX FIFO with an issue FSM that paces bytes to the uart. RX FIFO captures received bytes and keeps a sticky overrun flag.
- RX capture is suppressed while the software upgrader owns the UART.

Parameters:
- TX_DEPTH, 8, TX FIFO entries; power of 2, at least 2
- RX_DEPTH, 8, RX FIFO entries; power of 2, at least 2
- BUSY_TIMEOUT, 15, max cycles to wait for tx_busy to rise after tx_valid; range 1..255

Ports:
- clk  in  1  system clock
- rstb  in  1  reset; synchronous, active-low
- uart_wr_req  in  1  core write strobe, one byte per cycle
- uart_wr_data  in  8  byte to transmit
- uart_wr_ready  out  1  write accepted when high together with uart_wr_req
- uart_rd_req  in  1  core read strobe
- uart_rd_data  out  8  read byte, registered
- uart_rd_ready  out  1  one-cycle pulse; uart_rd_data is valid in that cycle
- uart_txfifo_full  out  1  TX FIFO full
- uart_rxfifo_empty  out  1  RX FIFO empty
- tx_valid  out  1  one-cycle byte-issue pulse to uart
- tx_data  out  8  byte to uart, held until the next issue
- tx_busy  in  1  uart serializing
- rx_valid  in  1  one-cycle pulse, byte received
- rx_data  in  8  received byte
- during_sw_upgrade  in  1  upgrader owns RX
- overrun_clr  in  1  clears rx_overrun
- rx_overrun  out  1  sticky: an RX byte was dropped on a full FIFO

Behaviour:
- Reset values (rstb=0 at a clk edge): both FIFOs empty, TX FSM=IDLE, tx_valid=0, tx_data=0, uart_rd_data=0, uart_rd_ready=0, rx_overrun=0. Status after reset: uart_wr_ready=1, uart_txfifo_full=0, uart_rxfifo_empty=1.
- Reset mid-operation: the in-flight byte is abandoned and all queued bytes are discarded.
- FIFO counts are $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH. Full and empty flags are decoded from the registered count.
- TX write:
  - uart_wr_ready = !uart_txfifo_full, combinational from registered state.
  - On wr_req && wr_ready the byte is pushed at the edge.
  - A write while full is ignored (no error flag); a same-cycle pop does not open space.
- TX FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if TX FIFO is non-empty and tx_busy=0 → pop head, tx_data<=head, tx_valid<=1 (next cycle only), go to WAIT_BUSY with timer=0.
  - WAIT_BUSY: if tx_busy=1 → WAIT_DONE. Otherwise timer++. When timer reaches BUSY_TIMEOUT → IDLE (byte treated as consumed).
  - WAIT_DONE: if tx_busy=0 → IDLE.
  - Latency: a byte written at edge N into an empty FIFO with the uart idle gives tx_valid high in cycle N+2.
  - Only one byte is in flight at a time.
- RX capture:
  - On rx_valid with during_sw_upgrade=0: push rx_data if not full.
  - If full: drop the byte and set rx_overrun.
  - rx_valid with during_sw_upgrade=1: byte discarded, no overrun.
  - Simultaneous push and pop on a full RX FIFO: pop first, push accepted, count unchanged, no overrun.
- RX read:
  - uart_rd_req at edge N: if non-empty, pop; uart_rd_data<=head and uart_rd_ready=1 during cycle N+1.
  - If empty: uart_rd_data<=8'h00 and uart_rd_ready still pulses.
  - uart_rd_data holds its value between reads.
  - Back-to-back reads pop one byte per cycle.
- rx_overrun: overrun_clr=1 clears it. If an overrun occurs in the same cycle, set wins.

Optional Feature:
- Macro UART_LOOPBACK_EN.
- Defined:
  - Extra input port loopback_en (1 bit).
  - When loopback_en=1, each byte popped in IDLE is pushed into the RX FIFO on the following edge instead of being sent: tx_valid stays 0 and the FSM returns to IDLE directly.
  - rx_valid is ignored while loopback_en=1. A loopback push into a full RX FIFO drops the byte and sets rx_overrun.
  - during_sw_upgrade=1 forces loopback off.
- Undefined: port absent; behaviour exactly as above.

Test Plan:
- Reset, then write 0x41 with tx_busy=0. tx_busy model rises 1 cycle after tx_valid and stays high 10 cycles. → tx_valid in the 2nd cycle after the write, tx_data=0x41; a second queued byte is not issued until tx_busy falls.
- Write 8 bytes 0x00..0x07 with tx_busy held 1. → uart_txfifo_full=1, uart_wr_ready=0; a 9th write is ignored. Release tx_busy → bytes appear on tx_data in order 0x00..0x07.
- tx_busy never rises → FSM returns to IDLE after BUSY_TIMEOUT=15 cycles and issues the next byte.
- Inject 9 rx_valid bytes 0x10..0x18 with no reads. → rx_overrun=1, and reads return 0x10..0x17, each with an rd_ready pulse 1 cycle after req. A 9th read returns 0x00 with ready=1. overrun_clr → rx_overrun=0.
- during_sw_upgrade=1, inject 0x55 → uart_rxfifo_empty stays 1, rx_overrun stays 0.
- (UART_LOOPBACK_EN) loopback_en=1, write 0xA5 → no tx_valid; uart_rxfifo_empty falls; read returns 0xA5.

Source files
------------

// File: rtl/uart_fifo_bridge.sv
// Core-side byte buffering between the UART register interface and the uart byte engine.
// Optional internal TX->RX loopback is compiled in with `define UART_LOOPBACK_EN.
module uart_fifo_bridge #(
  parameter int unsigned TX_DEPTH     = 8,
  parameter int unsigned RX_DEPTH     = 8,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       uart_wr_req,
  input  logic [7:0] uart_wr_data,
  output logic       uart_wr_ready,
  input  logic       uart_rd_req,
  output logic [7:0] uart_rd_data,
  output logic       uart_rd_ready,
  output logic       uart_txfifo_full,
  output logic       uart_rxfifo_empty,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       during_sw_upgrade,
`ifdef UART_LOOPBACK_EN
  input  logic       loopback_en,
`endif
  input  logic       overrun_clr,
  output logic       rx_overrun
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;
  localparam int unsigned TMR_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_t;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr;
  logic [TX_AW-1:0] tx_rd_ptr;
  logic [TX_CW-1:0] tx_count;
  logic             tx_empty;
  logic             tx_push;
  logic             tx_pop;
  logic [7:0]       tx_head;

  assign uart_txfifo_full = (tx_count == TX_CW'(TX_DEPTH));
  assign tx_empty         = (tx_count == '0);
  assign uart_wr_ready    = !uart_txfifo_full;
  assign tx_push          = uart_wr_req && !uart_txfifo_full;
  assign tx_head          = tx_mem[tx_rd_ptr];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= uart_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      tx_count <= tx_count + TX_CW'(tx_push) - TX_CW'(tx_pop);
    end
  end

  // Loopback is only honoured while the upgrader does not own the UART.
  logic lb_active;
`ifdef UART_LOOPBACK_EN
  assign lb_active = loopback_en && !during_sw_upgrade;
`else
  assign lb_active = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // TX issue FSM
  // ---------------------------------------------------------------------------
  tx_state_t        state;
  tx_state_t        state_nxt;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;
  logic [TMR_W-1:0] timer_inc;
  logic             lb_valid;
  logic [7:0]       lb_data;

  assign timer_inc = timer + TMR_W'(1);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    tx_pop    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!tx_empty && !tx_busy) begin
          tx_pop = 1'b1;
          if (!lb_active) begin
            state_nxt = WAIT_BUSY;
            timer_nxt = '0;
          end
        end
      end
      WAIT_BUSY: begin
        // Give up on a silent uart and treat the byte as consumed.
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else begin
          timer_nxt = timer_inc;
          if (timer_inc == TMR_W'(BUSY_TIMEOUT)) state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state    <= IDLE;
      timer    <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      lb_valid <= 1'b0;
      lb_data  <= '0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      tx_valid <= tx_pop && !lb_active;
      lb_valid <= tx_pop && lb_active;
      if (tx_pop && !lb_active) tx_data <= tx_head;
      if (tx_pop && lb_active)  lb_data <= tx_head;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr;
  logic [RX_AW-1:0] rx_rd_ptr;
  logic [RX_CW-1:0] rx_count;
  logic             rx_full;
  logic             rx_push_req;
  logic [7:0]       rx_push_data;
  logic             rx_push;
  logic             rx_pop;
  logic             rx_ovf;

  assign rx_full           = (rx_count == RX_CW'(RX_DEPTH));
  assign uart_rxfifo_empty = (rx_count == '0);

  // A pending loopback byte takes the write port ahead of the uart.
  assign rx_push_req  = lb_valid || (rx_valid && !during_sw_upgrade && !lb_active);
  assign rx_push_data = lb_valid ? lb_data : rx_data;
  assign rx_pop       = uart_rd_req && !uart_rxfifo_empty;
  assign rx_push      = rx_push_req && (!rx_full || rx_pop);
  assign rx_ovf       = rx_push_req && rx_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_push_data;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      rx_wr_ptr     <= '0;
      rx_rd_ptr     <= '0;
      rx_count      <= '0;
      rx_overrun    <= 1'b0;
      uart_rd_data  <= '0;
      uart_rd_ready <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      rx_count <= rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);
      if (rx_ovf)           rx_overrun <= 1'b1;
      else if (overrun_clr) rx_overrun <= 1'b0;
      uart_rd_ready <= uart_rd_req;
      if (uart_rd_req) uart_rd_data <= rx_pop ? rx_mem[rx_rd_ptr] : 8'h00;
    end
  end

endmodule
